// File: rtl/arb_gnt_mux.sv
// arb_gnt_mux: consumes a 4-way arbiter's one-hot grant, latches the winner
// and forwards its valid/data/last stream through one registered output port.
// o_lock stays high from grant capture until the last beat leaves downstream.
// Optional build macro ARB_GNT_MUX_BEAT_CNT_EN adds o_beat_cnt (beats in the
// most recently completed transfer, saturating at 255).
module arb_gnt_mux #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32,
   parameter int SRC_W  = 2
) (
   input  logic                    i_clk,
   input  logic                    i_nrst,
   input  logic [N_REQ-1:0]        i_gnt,
   input  logic [N_REQ-1:0]        i_valid,
   input  logic [N_REQ*DATA_W-1:0] i_data,
   input  logic [N_REQ-1:0]        i_last,
   output logic [N_REQ-1:0]        o_ready,
   output logic                    o_valid,
   output logic [DATA_W-1:0]       o_data,
   output logic                    o_last,
   output logic [SRC_W-1:0]        o_src,
   input  logic                    i_ready,
   output logic                    o_lock,
`ifdef ARB_GNT_MUX_BEAT_CNT_EN
   output logic [7:0]              o_beat_cnt,
`endif
   output logic                    o_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [SRC_W-1:0]    sel_q, sel_d;
   logic                err_q, err_d;

   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                last_q, last_d;
   logic [SRC_W-1:0]    src_q, src_d;

   logic                gnt_onehot;
   logic [SRC_W-1:0]    gnt_idx;
   logic                up_ready;
   logic                sel_valid;
   logic                sel_last;
   logic [DATA_W-1:0]   sel_data;
   logic                accept;
   logic                drain_done;

   // Grant decode: one-hot test and index encode of the arbiter grant.
   always_comb begin
      gnt_onehot = (i_gnt != '0) && ((i_gnt & (i_gnt - N_REQ'(1))) == '0);
      gnt_idx    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (i_gnt[k]) begin
            gnt_idx = SRC_W'(k);
         end
      end
   end

   // The output register can take a new beat when empty or being emptied.
   assign up_ready   = !valid_q || i_ready;
   assign sel_valid  = i_valid[sel_q];
   assign sel_last   = i_last[sel_q];
   assign sel_data   = i_data[sel_q*DATA_W +: DATA_W];
   assign accept     = (state_q == ST_XFER) && sel_valid && up_ready;
   assign drain_done = (state_q == ST_DRAIN) && valid_q && i_ready;

   // Only the latched requester ever sees ready, and only while transferring.
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_ready
         assign o_ready[gi] = (state_q == ST_XFER) && (sel_q == SRC_W'(gi)) && up_ready;
      end
   endgenerate

   // Next-state logic: capture grant, stream beats, wait for last beat to drain.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_onehot) begin
               state_d = ST_XFER;
               sel_d   = gnt_idx;
            end else if (i_gnt != '0) begin
               err_d = 1'b1;
            end
         end
         ST_XFER: begin
            if (accept && sel_last) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, selected index and sticky grant-error flag.
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
      end
   end

   // Output register next value: load on accept, else empty when taken.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      src_d   = src_q;
      if (accept) begin
         valid_d = 1'b1;
         data_d  = sel_data;
         last_d  = sel_last;
         src_d   = sel_q;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end
   end

   // Output register; payload holds whenever no new beat loads.
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         src_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
         src_q   <= src_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_last  = last_q;
   assign o_src   = src_q;
   assign o_lock  = (state_q != ST_IDLE);
   assign o_err   = err_q;

`ifdef ARB_GNT_MUX_BEAT_CNT_EN
   logic [7:0] run_q;
   logic [7:0] cnt_q;

   // Running beat count per transfer, published when the last beat drains.
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         run_q <= 8'd0;
         cnt_q <= 8'd0;
      end else begin
         if ((state_q == ST_IDLE) && gnt_onehot) begin
            run_q <= 8'd0;
         end else if (accept && (run_q != 8'hFF)) begin
            run_q <= run_q + 8'd1;
         end
         if (drain_done) begin
            cnt_q <= run_q;
         end
      end
   end

   assign o_beat_cnt = cnt_q;
`endif

endmodule
